// File: rtl/led_pkg.sv
// led_pkg: shared sizes, off-levels and scan state for the LED matrix driver
package led_pkg;
  localparam int COLS = 4;
  localparam int ROWS = 8;
  localparam logic [ROWS-1:0] LED_OFF = 8'hFF;
  localparam logic [COLS-1:0] COL_OFF = 4'hF;
  typedef enum logic {BLANK, DRIVE} scan_state_e;
endpackage

// File: rtl/led_matrix_scan_pwm_if.sv
// led_matrix_scan_pwm_if: column holding registers in, row/column drive out
//   leds1..4 (8) holding registers, 0 = lit; brightness (4) only with LED_SCAN_DIM_EN
//   leds (8) row drive, lcol (4) column select, frame_start (1) snapshot pulse
interface led_matrix_scan_pwm_if;
  import led_pkg::*;
  logic [ROWS-1:0] leds1, leds2, leds3, leds4;
`ifdef LED_SCAN_DIM_EN
  logic [3:0] brightness;
`endif
  logic [ROWS-1:0] leds;
  logic [COLS-1:0] lcol;
  logic frame_start;
  modport master (
`ifdef LED_SCAN_DIM_EN
    output brightness,
`endif
    output leds1, leds2, leds3, leds4,
    input leds, lcol, frame_start
  );
  modport slave (
`ifdef LED_SCAN_DIM_EN
    input brightness,
`endif
    input leds1, leds2, leds3, leds4,
    output leds, lcol, frame_start
  );
endinterface

// File: rtl/led_pwm_slot.sv
// led_pwm_slot: splits the drive window into 16 slots of S clocks and enables rows in slots k < bright
//   clk12MHz, rst (async, active-high); state: current scan state; bright: latched duty
//   row_en: rows may be lit this cycle (meaningful only while state == DRIVE)
module led_pwm_slot
  import led_pkg::*;
#(
  parameter int S = 3
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  scan_state_e state,
  input  logic [3:0]  bright,
  output logic        row_en
);
  localparam int SW = S > 1 ? $clog2(S) : 1;
  logic [SW-1:0] sub;
  // remainder clocks after slot 15 push k past 15, never above 31, so they read as off
  logic [4:0] k;
  always_ff @(posedge clk12MHz or posedge rst)
    if (rst) begin
      sub <= '0;
      k <= '0;
    end else if (state == BLANK) begin
      sub <= '0;
      k <= '0;
    end else begin
      sub <= sub == SW'(S - 1) ? '0 : sub + SW'(1);
      k <= sub == SW'(S - 1) ? k + 5'd1 : k;
    end
  assign row_en = k < {1'b0, bright};
endmodule

// File: rtl/led_matrix_scan_pwm.sv
// led_matrix_scan_pwm: frame-snapshotted 8x4 LED column scanner with blanking gaps
//   clk12MHz (12 MHz), rst (async, active-high), bus: led_matrix_scan_pwm_if.slave
//   Optional dimming enabled by defining LED_SCAN_DIM_EN (adds bus.brightness).
module led_matrix_scan_pwm
  import led_pkg::*;
#(
  parameter int COL_CYCLES   = 3000,
  parameter int BLANK_CYCLES = 24
) (
  input logic clk12MHz,
  input logic rst,
  led_matrix_scan_pwm_if.slave bus
);
  localparam int CW  = $clog2(COL_CYCLES);
  localparam int CLW = $clog2(COLS);
  if (COL_CYCLES < BLANK_CYCLES + 16) begin : g_bad_params
    $error("COL_CYCLES must be >= BLANK_CYCLES + 16");
  end
  scan_state_e state;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CLW-1:0] col;
  logic [ROWS-1:0] shadow [COLS];
  logic [ROWS-1:0] leds_q;
  logic [COLS-1:0] lcol_q;
  logic fs_q, last, snap, row_en;
  assign last = cnt == CW'(COL_CYCLES - 1);
  assign cnt_nx = last ? '0 : cnt + CW'(1);
  assign snap = state == BLANK && col == '0 && cnt == '0;
`ifdef LED_SCAN_DIM_EN
  logic [3:0] bright_shadow;
  always_ff @(posedge clk12MHz or posedge rst)
    if (rst) bright_shadow <= '0;
    else if (snap) bright_shadow <= bus.brightness;
  led_pwm_slot #(.S((COL_CYCLES - BLANK_CYCLES) / 16)) u_pwm (
    .clk12MHz(clk12MHz),
    .rst(rst),
    .state(state),
    .bright(bright_shadow),
    .row_en(row_en)
  );
`else
  assign row_en = 1'b1;
`endif
  always_ff @(posedge clk12MHz or posedge rst)
    if (rst) begin
      state <= BLANK;
      cnt <= '0;
      col <= '0;
      shadow <= '{default: LED_OFF};
      leds_q <= LED_OFF;
      lcol_q <= COL_OFF;
      fs_q <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      col <= last ? col + CLW'(1) : col;
      state <= cnt_nx < CW'(BLANK_CYCLES) ? BLANK : DRIVE;
      fs_q <= snap;
      if (snap) shadow <= '{bus.leds1, bus.leds2, bus.leds3, bus.leds4};
      lcol_q <= state == DRIVE ? ~(COLS'(1) << col) : COL_OFF;
      leds_q <= state == DRIVE && row_en ? shadow[col] : LED_OFF;
    end
  assign bus.leds = leds_q;
  assign bus.lcol = lcol_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_led_matrix_scan_pwm.sv
// tb_led_matrix_scan_pwm: randomized scan/snapshot checks against a time-indexed frame model
module tb_led_matrix_scan_pwm;
  localparam int CC = 64;
  localparam int BC = 8;
  localparam int FR = 4 * CC;
  localparam int S = (CC - BC) / 16;
  logic clk12MHz = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  led_matrix_scan_pwm_if bus();
  led_matrix_scan_pwm #(.COL_CYCLES(CC), .BLANK_CYCLES(BC)) dut (
    .clk12MHz(clk12MHz),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk12MHz = ~clk12MHz;

  // reference: t counts clocks since reset release; everything follows from t alone
  int t;
  logic [7:0] m_snap [4];
  int m_bright;
  logic [7:0] e_leds;
  logic [3:0] e_lcol;
  logic e_fs;
  always @(posedge clk12MHz or posedge rst) begin
    int p, c, k;
    bit on;
    if (rst) begin
      t = 0;
      e_leds = 8'hFF;
      e_lcol = 4'hF;
      e_fs = 1'b0;
    end else begin
      p = t % FR;
      c = p % CC;
      k = p / CC;
      if (p == 0) begin
        m_snap = '{bus.leds1, bus.leds2, bus.leds3, bus.leds4};
`ifdef LED_SCAN_DIM_EN
        m_bright = int'(bus.brightness);
`endif
      end
      on = c >= BC;
`ifdef LED_SCAN_DIM_EN
      on = on && ((c - BC) / S < m_bright);
`endif
      e_fs = p == 0;
      e_lcol = c >= BC ? ~(4'b0001 << k) : 4'hF;
      e_leds = on ? m_snap[k] : 8'hFF;
      t++;
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk12MHz);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go(2);
    rst = 1'b0;
  endtask

  task automatic set_leds(input logic [7:0] a, b, c, d);
    bus.leds1 = a;
    bus.leds2 = b;
    bus.leds3 = c;
    bus.leds4 = d;
  endtask

  task automatic test_reset();
    set_leds(8'hA5, 8'h5A, 8'h3C, 8'hC3);
`ifdef LED_SCAN_DIM_EN
    bus.brightness = 4'd15;
`endif
    rst = 1'b1;
    go(2);
    checks += 3;
    if (bus.leds !== 8'hFF) begin errors++; $display("FAIL reset_leds got %h want ff", bus.leds); end
    if (bus.lcol !== 4'hF) begin errors++; $display("FAIL reset_lcol got %h want f", bus.lcol); end
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
    rst = 1'b0;
    go(1);
    checks++;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL first_fs got %b want 1", bus.frame_start); end
    go(1);
    checks++;
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL fs_one_cycle got %b want 0", bus.frame_start); end
    go(6);
    checks++;
    if (bus.lcol !== 4'hF) begin errors++; $display("FAIL still_blank lcol got %h want f", bus.lcol); end
    go(1);
    checks += 2;
    if (bus.lcol !== 4'hE) begin errors++; $display("FAIL first_col lcol got %h want e", bus.lcol); end
    if (bus.leds !== 8'hA5) begin errors++; $display("FAIL first_col leds got %h want a5", bus.leds); end
    go(20);
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (bus.leds !== 8'hFF) begin errors++; $display("FAIL midrst_leds got %h want ff", bus.leds); end
    if (bus.lcol !== 4'hF) begin errors++; $display("FAIL midrst_lcol got %h want f", bus.lcol); end
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL midrst_fs got %b want 0", bus.frame_start); end
    @(negedge clk12MHz);
    rst = 1'b0;
    go(1);
    checks++;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs got %b want 1", bus.frame_start); end
  endtask

  task automatic test_scan_order();
    logic [7:0] pat [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    int lit [4] = '{0, 0, 0, 0};
    int blank = 0;
    int want;
`ifdef LED_SCAN_DIM_EN
    want = 2 * 15 * S;
`else
    want = 2 * (CC - BC);
`endif
    set_leds(pat[0], pat[1], pat[2], pat[3]);
    do_reset();
    for (int i = 1; i <= 2 * FR; i++) begin
      go(1);
      checks++;
      if (bus.leds !== e_leds || bus.lcol !== e_lcol || bus.frame_start !== e_fs) begin
        errors++;
        $display("FAIL scan cyc=%0d leds %h/%h lcol %h/%h fs %b/%b", i, bus.leds, e_leds, bus.lcol, e_lcol, bus.frame_start, e_fs);
      end
      for (int j = 0; j < 4; j++)
        if (bus.lcol == ~(4'b0001 << j) && bus.leds == pat[j]) lit[j]++;
      if (bus.lcol == 4'hF && bus.leds == 8'hFF) blank++;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (lit[j] != want) begin errors++; $display("FAIL col%0d_lit got %0d want %0d", j, lit[j], want); end
    end
    checks++;
    if (blank != 2 * 4 * BC) begin errors++; $display("FAIL blank_count got %0d want %0d", blank, 2 * 4 * BC); end
  endtask

  task automatic test_tear_free();
    set_leds(8'hFF, 8'hFF, 8'h00, 8'hFF);
`ifdef LED_SCAN_DIM_EN
    bus.brightness = 4'd15;
`endif
    do_reset();
    go(CC + 20);
    bus.leds3 = 8'hFF;
    go(CC);
    checks += 2;
    if (bus.lcol !== 4'hB) begin errors++; $display("FAIL tear_lcol got %h want b", bus.lcol); end
    if (bus.leds !== 8'h00) begin errors++; $display("FAIL tear_old got %h want 00", bus.leds); end
    go(FR);
    checks += 2;
    if (bus.lcol !== 4'hB) begin errors++; $display("FAIL tear_lcol2 got %h want b", bus.lcol); end
    if (bus.leds !== 8'hFF) begin errors++; $display("FAIL tear_new got %h want ff", bus.leds); end
  endtask

  task automatic test_period_random();
    int last = -1;
    int n = 0;
    do_reset();
    for (int i = 1; i <= 10 * FR; i++) begin
      go(1);
      checks += 2;
      if (bus.leds !== e_leds || bus.lcol !== e_lcol || bus.frame_start !== e_fs) begin
        errors++;
        $display("FAIL rand cyc=%0d leds %h/%h lcol %h/%h fs %b/%b", i, bus.leds, e_leds, bus.lcol, e_lcol, bus.frame_start, e_fs);
      end
      if ($countones(~bus.lcol) > 1) begin errors++; $display("FAIL two_cols cyc=%0d lcol %h", i, bus.lcol); end
      if (bus.frame_start === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != FR) begin errors++; $display("FAIL period got %0d want %0d", i - last, FR); end
        end
        last = i;
        n++;
      end
      if ($urandom_range(7) == 0)
        set_leds(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
`ifdef LED_SCAN_DIM_EN
      if ($urandom_range(15) == 0) bus.brightness = 4'($urandom);
`endif
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL frame_count got %0d want 10", n); end
  endtask

`ifdef LED_SCAN_DIM_EN
  task automatic test_dim();
    int lit [4] = '{0, 0, 0, 0};
    int dark = 0;
    int bad = 0;
    set_leds(8'h00, 8'h00, 8'h00, 8'h00);
    bus.brightness = 4'd4;
    do_reset();
    for (int i = 1; i <= FR; i++) begin
      go(1);
      for (int j = 0; j < 4; j++)
        if (bus.lcol == ~(4'b0001 << j) && bus.leds == 8'h00) lit[j]++;
      if (bus.lcol != 4'hF && bus.leds == 8'hFF) dark++;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (lit[j] != 4 * S) begin errors++; $display("FAIL dim4_col%0d got %0d want %0d", j, lit[j], 4 * S); end
    end
    checks++;
    if (dark != 4 * (CC - BC - 4 * S)) begin errors++; $display("FAIL dim4_dark got %0d want %0d", dark, 4 * (CC - BC - 4 * S)); end
    bus.brightness = 4'd0;
    do_reset();
    for (int i = 1; i <= FR; i++) begin
      go(1);
      if (bus.leds != 8'hFF) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dim0 lit_cycles got %0d want 0", bad); end
  endtask

  task automatic test_dim_change();
    int lit [2] = '{0, 0};
    set_leds(8'h00, 8'h00, 8'h00, 8'h00);
    bus.brightness = 4'd4;
    do_reset();
    for (int i = 1; i <= 2 * FR; i++) begin
      go(1);
      checks++;
      if (bus.leds !== e_leds || bus.lcol !== e_lcol) begin
        errors++;
        $display("FAIL dimchg cyc=%0d leds %h/%h lcol %h/%h", i, bus.leds, e_leds, bus.lcol, e_lcol);
      end
      if (bus.lcol != 4'hF && bus.leds == 8'h00) lit[(i - 1) / FR]++;
      if (i == 100) bus.brightness = 4'd10;
    end
    checks += 2;
    if (lit[0] != 4 * 4 * S) begin errors++; $display("FAIL dimchg_old got %0d want %0d", lit[0], 4 * 4 * S); end
    if (lit[1] != 4 * 10 * S) begin errors++; $display("FAIL dimchg_new got %0d want %0d", lit[1], 4 * 10 * S); end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_period_random();
`ifdef LED_SCAN_DIM_EN
    test_dim();
    test_dim_change();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
